// File: rtl/mem_arbiter_id.sv
// -----------------------------------------------------------------------------
// mem_arbiter_id
// Two-client arbiter merging the I-cache and D-cache line ports onto a single
// slow-memory port. Clients hold read/write until their one-cycle ready pulse;
// memory completes with a one-cycle mem_ready pulse. All outputs registered.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   read_D/write_D/addr_D/wdata_D -> rdata_D/ready_D   D-cache side
//   read_I/write_I/addr_I/wdata_I -> rdata_I/ready_I   I-cache side
//   mem_read/mem_write/mem_addr/mem_wdata <- mem_rdata/mem_ready  memory side
//
// Build option:
//   ARB_RR_EN  defined   : round-robin between colliding requests using a
//                          1-bit last_grant register (0 = I, 1 = D).
//              undefined : fixed D-over-I priority.
// -----------------------------------------------------------------------------
module mem_arbiter_id #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_D,
  input  logic              write_D,
  input  logic [ADDR_W-1:0] addr_D,
  input  logic [DATA_W-1:0] wdata_D,
  output logic [DATA_W-1:0] rdata_D,
  output logic              ready_D,
  input  logic              read_I,
  input  logic              write_I,
  input  logic [ADDR_W-1:0] addr_I,
  input  logic [DATA_W-1:0] wdata_I,
  output logic [DATA_W-1:0] rdata_I,
  output logic              ready_I,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RELEASE} state_t;

  state_t state_q;

  logic req_d, req_i, pick_d;

  assign req_d = read_D | write_D;
  assign req_i = read_I | write_I;

`ifdef ARB_RR_EN
  logic last_grant_q;  // 1 = D was granted last, 0 = I
  // On a collision the client that was not granted last wins.
  assign pick_d = req_d & (~req_i | ~last_grant_q);
`else
  assign pick_d = req_d;
`endif

  // The memory-side outputs double as the latched request: they are loaded
  // once on the grant edge and held until mem_ready, so client inputs that
  // change while busy have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata_D      <= '0;
      rdata_I      <= '0;
      ready_D      <= 1'b0;
      ready_I      <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      ready_D <= 1'b0;
      ready_I <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            // read+write together is treated as a write
            mem_write <= write_D;
            mem_read  <= read_D & ~write_D;
            mem_addr  <= addr_D;
            mem_wdata <= wdata_D;
            state_q   <= BUSY_D;
`ifdef ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
          end else if (req_i) begin
            mem_write <= write_I;
            mem_read  <= read_I & ~write_I;
            mem_addr  <= addr_I;
            mem_wdata <= wdata_I;
            state_q   <= BUSY_I;
`ifdef ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            if (mem_read) rdata_D <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ready_D   <= 1'b1;
            state_q   <= RELEASE;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            if (mem_read) rdata_I <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ready_I   <= 1'b1;
            state_q   <= RELEASE;
          end
        end
        // One dead cycle so a client still holding its request in the ready
        // cycle is not granted a second time.
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_id.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for mem_arbiter_id. A fixed-latency (L=4)
// memory model answers mem_read/mem_write; tests drive inputs on negedge and
// sample outputs on negedge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_id;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int L      = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              read_D = 1'b0, write_D = 1'b0;
  logic [ADDR_W-1:0] addr_D = '0;
  logic [DATA_W-1:0] wdata_D = '0;
  logic [DATA_W-1:0] rdata_D;
  logic              ready_D;
  logic              read_I = 1'b0, write_I = 1'b0;
  logic [ADDR_W-1:0] addr_I = '0;
  logic [DATA_W-1:0] wdata_I = '0;
  logic [DATA_W-1:0] rdata_I;
  logic              ready_I;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [DATA_W-1:0] mem_val = '0;
  logic              mdl_rdy = 1'b0;
  logic              spur_rdy = 1'b0;
  assign mem_rdata = mem_val;
  assign mem_ready = mdl_rdy | spur_rdy;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_rd_D = '0;
  logic [DATA_W-1:0] exp_rd_I = '0;

  mem_arbiter_id #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_D(read_D), .write_D(write_D), .addr_D(addr_D), .wdata_D(wdata_D),
    .rdata_D(rdata_D), .ready_D(ready_D),
    .read_I(read_I), .write_I(write_I), .addr_I(addr_I), .wdata_I(wdata_I),
    .rdata_I(rdata_I), .ready_I(ready_I),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: mem_ready rises L cycles after the request is first seen.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0; mdl_rdy = 1'b0;
      end else if (mdl_rdy) begin
        cnt = 0; mdl_rdy = 1'b0;
      end else if (mem_read | mem_write) begin
        if (cnt == L) mdl_rdy = 1'b1;
        else cnt++;
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_read, mem_write, ready_D, ready_I} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {mem_read, mem_write, ready_D, ready_I});
    end
    checks++;
    if ({mem_addr, mem_wdata, rdata_D, rdata_I} !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, rdata_D, rdata_I});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // D read; expects mem_read one cycle after request and ready_D at cycle 6.
  task automatic test_d_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n; bit saw_i;
    n = 0; saw_i = 0;
    mem_val = d; addr_D = a; read_D = 1'b1;
    while (n < 30) begin
      @(negedge clk); n++;
      if (ready_I) saw_i = 1;
      if (n == 1) begin
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== a) begin
          errors++; $display("FAIL d_read_grant got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=%h", mem_read, mem_write, mem_addr, a);
        end
      end
      if (ready_D) break;
    end
    read_D = 1'b0;
    exp_rd_D = d;
    checks++;
    if (n != 6) begin errors++; $display("FAIL d_read_latency got %0d want 6", n); end
    checks++;
    if (rdata_D !== d) begin errors++; $display("FAIL d_read_data got %h want %h", rdata_D, d); end
    checks++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL d_read_memclr got %b want 0", mem_read); end
    @(negedge clk);
    checks++;
    if (ready_D !== 1'b0 || saw_i) begin
      errors++; $display("FAIL d_read_pulse got ready_D=%b ready_I_seen=%b want 0 0", ready_D, saw_i);
    end
    @(negedge clk);
  endtask

  task automatic test_i_write();
    int n, pulses;
    n = 0; pulses = 0;
    addr_I = 28'h0000020; wdata_I = 128'h1234; write_I = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); n++;
      if (n == 1) begin
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h20 || mem_wdata !== 128'h1234) begin
          errors++; $display("FAIL i_write_grant got wr=%b rd=%b addr=%h wdata=%h want 1 0 20 1234", mem_write, mem_read, mem_addr, mem_wdata);
        end
      end
      if (ready_I) begin pulses++; write_I = 1'b0; end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL i_write_pulses got %0d want 1", pulses); end
    checks++;
    if (rdata_I !== exp_rd_I) begin errors++; $display("FAIL i_write_rdata got %h want %h", rdata_I, exp_rd_I); end
  endtask

  // Both clients read at once; d_first selects the expected service order.
  task automatic test_collision(input bit d_first);
    logic [ADDR_W-1:0] g[2];
    int ng, rd, ri; logic prev;
    ng = 0; rd = 0; ri = 0; prev = 1'b0;
    mem_val = 128'h77;
    addr_D = 28'h0000030; addr_I = 28'h0000040;
    read_D = 1'b1; read_I = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (mem_read && !prev) begin
        if (ng < 2) g[ng] = mem_addr;
        ng++;
      end
      prev = mem_read;
      if (ready_D) begin rd++; read_D = 1'b0; end
      if (ready_I) begin ri++; read_I = 1'b0; end
    end
    exp_rd_D = 128'h77; exp_rd_I = 128'h77;
    checks++;
    if (ng != 2 || rd != 1 || ri != 1) begin
      errors++; $display("FAIL collide_counts got grants=%0d rdyD=%0d rdyI=%0d want 2 1 1", ng, rd, ri);
    end else begin
      checks++;
      if (g[0] !== (d_first ? 28'h30 : 28'h40) || g[1] !== (d_first ? 28'h40 : 28'h30)) begin
        errors++; $display("FAIL collide_order got %h,%h want d_first=%0d", g[0], g[1], d_first);
      end
    end
  endtask

  // D keeps read_D one cycle past ready_D: only one grant may result.
  task automatic test_held();
    int rises, pulses, after; logic prev;
    rises = 0; pulses = 0; after = -1; prev = 1'b0;
    mem_val = 128'hC3C3; addr_D = 28'h0000050; read_D = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_read && !prev) rises++;
      prev = mem_read;
      if (after >= 0) after++;
      if (after == 1) read_D = 1'b0;
      if (ready_D) begin pulses++; after = 0; end
    end
    read_D = 1'b0;
    exp_rd_D = 128'hC3C3;
    checks++;
    if (rises != 1 || pulses != 1) begin
      errors++; $display("FAIL held_regrant got mem_read_rises=%0d ready_D=%0d want 1 1", rises, pulses);
    end
  endtask

  task automatic test_spurious();
    int pulses;
    pulses = 0;
    mem_val = {4{32'hDEADBEEF}};
    spur_rdy = 1'b1;
    @(negedge clk);
    spur_rdy = 1'b0;
    if (ready_D | ready_I) pulses++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ready_D | ready_I) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL spur_ready got %0d want 0", pulses); end
    checks++;
    if (rdata_D !== exp_rd_D || rdata_I !== exp_rd_I) begin
      errors++; $display("FAIL spur_rdata got D=%h I=%h want D=%h I=%h", rdata_D, rdata_I, exp_rd_D, exp_rd_I);
    end
  endtask

  // read_D and write_D together is a write; rdata_D must not change.
  task automatic test_rw_both();
    int n;
    n = 0;
    mem_val = 128'h9999; addr_D = 28'h0000060; wdata_D = 128'hABCD;
    read_D = 1'b1; write_D = 1'b1;
    while (n < 30) begin
      @(negedge clk); n++;
      if (n == 1) begin
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 128'hABCD) begin
          errors++; $display("FAIL rw_both_grant got wr=%b rd=%b wdata=%h want 1 0 abcd", mem_write, mem_read, mem_wdata);
        end
      end
      if (ready_D) break;
    end
    read_D = 1'b0; write_D = 1'b0;
    checks++;
    if (n != 6 || rdata_D !== exp_rd_D) begin
      errors++; $display("FAIL rw_both_done got n=%0d rdata=%h want 6 %h", n, rdata_D, exp_rd_D);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int pulses;
    pulses = 0;
    mem_val = 128'h5555; addr_D = 28'h0000070; read_D = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL areset_busy got mem_read=%b want 1", mem_read); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, ready_D, ready_I} !== 4'b0 || mem_addr !== '0 || rdata_D !== '0 || rdata_I !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL areset_outputs got rd=%b addr=%h rdata_D=%h want all 0", mem_read, mem_addr, rdata_D);
    end
    read_D = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ready_D | mem_read) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL areset_after got %0d activity cycles want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_d_read(28'h0000010, {16{8'hA5}});
    test_i_write();
    test_collision(1'b1);
    test_d_read(28'h0000018, 128'h0102_0304);
`ifdef ARB_RR_EN
    test_collision(1'b0);
`else
    test_collision(1'b1);
`endif
    test_held();
    test_spurious();
    test_rw_both();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
